// File: rtl/irq_pkg.sv
// ============================================================================
// irq_pkg: register offsets, FSM encoding and sizing shared by irq_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package irq_pkg;

  localparam int IRQ_MAX_SRC = 16;
  localparam int IRQ_ID_W    = 4;

  localparam logic [7:0] IRQ_PEND_OFS = 8'h00;
  localparam logic [7:0] IRQ_MASK_OFS = 8'h04;
  localparam logic [7:0] IRQ_STAT_OFS = 8'h08;
  localparam logic [7:0] IRQ_VEC_OFS  = 8'h10;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_SERVICE = 2'd1,
    IRQ_ST_RELEASE = 2'd2
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// irq_prio_enc: combinational priority encoder, lowest set index wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]  req,
  output logic [IRQ_ID_W-1:0] id,
  output logic                valid
);

  // Scan from the top down so the last match left standing is the lowest index.
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = IRQ_ID_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// irq_controller: memory-mapped, non-preemptive priority interrupt controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC = 4,
  parameter logic [31:0] BASE    = 32'h0000_0900
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  output logic               hit,
  output logic               irq,
  output logic [31:0]        irq_addr,
  input  logic               irq_ack
);

  irq_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [NUM_SRC-1:0]  src_d_q;
  logic [31:0]         vec_q [NUM_SRC];
  logic [31:0]         vec_d [NUM_SRC];
  logic [IRQ_ID_W-1:0] active_id_q, active_id_d;
  logic                irq_q, irq_d;
  logic [31:0]         irq_addr_q, irq_addr_d;

  logic [NUM_SRC-1:0]  src_rise;
  logic [NUM_SRC-1:0]  w1c_clr;
  logic [NUM_SRC-1:0]  svc_clr;
  logic [IRQ_ID_W-1:0] win_id;
  logic                win_valid;
  logic [31:0]         win_vec;
  logic [7:0]          ofs;
  logic                unused_addr_lsb;

  assign hit             = (addr[31:8] == BASE[31:8]);
  assign ofs             = {addr[7:2], 2'b00};
  assign src_rise        = src_irq & ~src_d_q;
  assign unused_addr_lsb = ^addr[1:0];
  assign irq             = irq_q;
  assign irq_addr        = irq_addr_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (pend_q & mask_q),
    .id    (win_id),
    .valid (win_valid)
  );

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win_id == IRQ_ID_W'(i)) begin
        win_vec = vec_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    vec_d       = vec_q;
    active_id_d = active_id_q;
    irq_d       = irq_q;
    irq_addr_d  = irq_addr_q;
    w1c_clr     = '0;
    svc_clr     = '0;

    if (we && hit) begin
      case (ofs)
        IRQ_PEND_OFS: w1c_clr = wd[NUM_SRC-1:0];
        IRQ_MASK_OFS: mask_d  = wd[NUM_SRC-1:0];
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (ofs == IRQ_VEC_OFS + 8'(4 * i)) begin
              vec_d[i] = wd;
            end
          end
        end
      endcase
    end

    case (state_q)
      IRQ_ST_IDLE: begin
        if (win_valid) begin
          active_id_d = win_id;
          irq_addr_d  = win_vec;
          irq_d       = 1'b1;
          state_d     = IRQ_ST_SERVICE;
        end
      end
      IRQ_ST_SERVICE: begin
        if (irq_ack) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (active_id_q == IRQ_ID_W'(i)) begin
              svc_clr[i] = 1'b1;
            end
          end
          irq_d   = 1'b0;
          state_d = IRQ_ST_RELEASE;
        end
      end
      IRQ_ST_RELEASE: begin
        // STATUS reads all-zero once the controller is idle again.
        active_id_d = '0;
        state_d     = IRQ_ST_IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IRQ_ST_IDLE;
      end
    endcase

    // A fresh edge beats any clear landing on the same bit.
    pend_d = (pend_q & ~w1c_clr & ~svc_clr) | src_rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IRQ_ST_IDLE;
      pend_q      <= '0;
      mask_q      <= '0;
      src_d_q     <= '0;
      active_id_q <= '0;
      irq_q       <= 1'b0;
      irq_addr_q  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      src_d_q     <= src_irq;
      active_id_q <= active_id_d;
      irq_q       <= irq_d;
      irq_addr_q  <= irq_addr_d;
      vec_q       <= vec_d;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (ofs)
        IRQ_PEND_OFS: rd = 32'(pend_q);
        IRQ_MASK_OFS: rd = 32'(mask_q);
        IRQ_STAT_OFS: rd = {(state_q != IRQ_ST_IDLE), 27'b0, active_id_q};
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (ofs == IRQ_VEC_OFS + 8'(4 * i)) begin
              rd = vec_q[i];
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
